pixel_pattern_gen: RTL and testbench

Parametrised test-pattern source for the pixel/MIPI paths. It is the successor to the fixed colorbar generator used in SoM simulation and bring-up. It emits fv/lv/data framing with configurable geometry, 1/2/4 pixels per clock, and four runtime-selectable patterns. It sits ahead of pixel_to_mipi, on silicon or in a bench, and drives known frames into the MIPI TX path.

---
 rtl/pixel_pattern_gen_if.sv | 12 +
 rtl/pixel_pattern_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_pixel_pattern_gen.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_pattern_gen_if.sv
// rtl/pixel_pattern_gen_if.sv - fv/lv/data pixel bus between a pattern source and its sink
interface pixel_pattern_gen_if #(
  parameter int DATA_WIDTH = 10,
  parameter int PPC        = 1
);
  logic                      pixel_fv;
  logic                      pixel_lv;
  logic [PPC*DATA_WIDTH-1:0] pixel_data;

  modport master (output pixel_fv, output pixel_lv, output pixel_data);
  modport slave  (input  pixel_fv, input  pixel_lv, input  pixel_data);
endinterface

// File: rtl/pixel_pattern_gen.sv
// rtl/pixel_pattern_gen.sv - framed test-pattern source (colorbar/ramp/checker/LFSR), 1/2/4 pixels per clock
// Define PATTERN_GEN_CRC_EN to add a per-frame CRC-16-CCITT of the active pixels on frame_crc.
module pixel_pattern_gen #(
  parameter int DATA_WIDTH = 10,
  parameter int PPC        = 1,
  parameter int H_ACTIVE   = 30,
  parameter int V_ACTIVE   = 40,
  parameter int H_BLANK    = 16,
  parameter int V_BLANK    = 64,
  parameter int FV_LEAD    = 8,
  parameter int FV_TRAIL   = 8,
  parameter int CHK_SHIFT  = 3
) (
  input  logic                       pixel_clk,
  input  logic                       pixel_rst_n,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  pixel_pattern_gen_if.master        pix,
  output logic [15:0]                frame_count,
  output logic                       busy,
  output logic [15:0]                frame_crc
);

  localparam int CNT_W    = 16;
  localparam int ROW_W    = 16;
  localparam int BAR_STEP = ((1 << DATA_WIDTH) - 1) / 7;
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;
  localparam logic [CNT_W-1:0] VB_LAST   = CNT_W'(V_BLANK - 1);
  localparam logic [CNT_W-1:0] FL_LAST   = CNT_W'(FV_LEAD - 1);
  localparam logic [CNT_W-1:0] HA_LAST   = CNT_W'(H_ACTIVE / PPC - 1);
  localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] FT_LAST   = CNT_W'(FV_TRAIL - 1);
  localparam logic [ROW_W-1:0] VA_LAST   = ROW_W'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VBLANK, S_FV_LEAD, S_ACTIVE, S_HBLANK, S_FV_TRAIL
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [1:0]                mode_q, mode_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [15:0]               frame_count_q, frame_count_d;
  logic                      busy_q, busy_d;
  logic                      fv_q, fv_d;
  logic                      lv_q, lv_d;
  logic [PPC*DATA_WIDTH-1:0] data_q, data_d;
  logic [PPC*DATA_WIDTH-1:0] pix_word;
  logic [15:0]               lfsr_walk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m, input int x, input int y,
                                                    input int fc, input logic [DATA_WIDTH-1:0] lf);
    int bar;
    logic [DATA_WIDTH-1:0] px;
    bar = 0;
    px  = '0;
    case (m)
      2'd0: begin
        // bar = (x*8)/H_ACTIVE as threshold compares, avoiding a divider
        for (int b = 1; b < 8; b++) begin
          if (x * 8 >= b * H_ACTIVE) bar = b;
        end
        px = DATA_WIDTH'(bar * BAR_STEP);
      end
      2'd1:    px = DATA_WIDTH'(x + y + fc);
      2'd2:    px = ((((x >> CHK_SHIFT) ^ (y >> CHK_SHIFT)) & 1) != 0) ? '1 : '0;
      default: px = lf;
    endcase
    return px;
  endfunction

  always_comb begin
    lfsr_walk = lfsr_q;
    pix_word  = '0;
    for (int k = 0; k < PPC; k++) begin
      lfsr_walk = lfsr_step(lfsr_walk);
      pix_word[k*DATA_WIDTH +: DATA_WIDTH] =
        pattern(mode_q, int'(cnt_q) * PPC + k, int'(row_q), int'(frame_count_q),
                lfsr_walk[DATA_WIDTH-1:0]);
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 1'b1;
    row_d         = row_q;
    mode_d        = mode_q;
    lfsr_d        = lfsr_q;
    frame_count_d = frame_count_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = S_VBLANK;
      end
      S_VBLANK: begin
        lfsr_d = LFSR_SEED;
        if (cnt_q == VB_LAST) begin
          state_d = S_FV_LEAD;
          cnt_d   = '0;
          mode_d  = mode;
        end
      end
      S_FV_LEAD: begin
        if (cnt_q == FL_LAST) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          row_d   = '0;
        end
      end
      S_ACTIVE: begin
        lfsr_d = lfsr_walk;
        if (cnt_q == HA_LAST) begin
          cnt_d   = '0;
          state_d = (row_q == VA_LAST) ? S_FV_TRAIL : S_HBLANK;
        end
      end
      S_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          row_d   = row_q + 1'b1;
        end
      end
      S_FV_TRAIL: begin
        // enable is only consulted here, so a dropped enable never truncates a frame
        if (cnt_q == FT_LAST) begin
          cnt_d         = '0;
          frame_count_d = frame_count_q + 1'b1;
          state_d       = enable ? S_VBLANK : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    fv_d   = (state_q == S_FV_LEAD) || (state_q == S_ACTIVE) ||
             (state_q == S_HBLANK)  || (state_q == S_FV_TRAIL);
    lv_d   = (state_q == S_ACTIVE);
    data_d = lv_d ? pix_word : '0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      row_q         <= '0;
      mode_q        <= '0;
      lfsr_q        <= LFSR_SEED;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
      fv_q          <= 1'b0;
      lv_q          <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      mode_q        <= mode_d;
      lfsr_q        <= lfsr_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
      fv_q          <= fv_d;
      lv_q          <= lv_d;
      data_q        <= data_d;
    end
  end

`ifdef PATTERN_GEN_CRC_EN
  logic [15:0] crc_run_q, crc_run_d;
  logic [15:0] frame_crc_q, frame_crc_d;

  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [PPC*DATA_WIDTH-1:0] w);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int k = 0; k < PPC; k++) begin
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
        fb = r[15] ^ w[k*DATA_WIDTH + i];
        r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return r;
  endfunction

  always_comb begin
    crc_run_d   = crc_run_q;
    frame_crc_d = frame_crc_q;
    if (state_q == S_VBLANK) begin
      crc_run_d = 16'hFFFF;
    end else if (state_q == S_ACTIVE) begin
      crc_run_d = crc_word(crc_run_q, pix_word);
    end
    if (state_q == S_FV_TRAIL && cnt_q == FT_LAST) frame_crc_d = crc_run_q;
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      crc_run_q   <= 16'hFFFF;
      frame_crc_q <= '0;
    end else begin
      crc_run_q   <= crc_run_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  assign frame_crc = '0;
`endif

  assign pix.pixel_fv   = fv_q;
  assign pix.pixel_lv   = lv_q;
  assign pix.pixel_data = data_q;
  assign frame_count    = frame_count_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_pixel_pattern_gen.sv
// tb/tb_pixel_pattern_gen.sv - scoreboard bench for pixel_pattern_gen with a frame-level reference model
module tb_pixel_pattern_gen;

  localparam int DW = 10, PPC = 1, HA = 30, VA = 40, HB = 16, VB = 64, FL = 8, FT = 8, CS = 3;
  localparam int H_CYC = HA / PPC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable;
  logic [1:0]  mode;
  logic [15:0] frame_count, frame_crc;
  logic        busy;

  logic        rst2_n, en2, done2;
  logic [1:0]  mode2;
  logic [15:0] frame_count2, frame_crc2;
  logic        busy2;

  pixel_pattern_gen_if #(.DATA_WIDTH(DW), .PPC(PPC)) pif ();
  pixel_pattern_gen_if #(.DATA_WIDTH(DW), .PPC(2))   pif2 ();

  pixel_pattern_gen #(
    .DATA_WIDTH(DW), .PPC(PPC), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .V_BLANK(VB), .FV_LEAD(FL), .FV_TRAIL(FT), .CHK_SHIFT(CS)
  ) dut (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .enable(enable), .mode(mode), .pix(pif),
    .frame_count(frame_count), .busy(busy), .frame_crc(frame_crc)
  );

  pixel_pattern_gen #(
    .DATA_WIDTH(DW), .PPC(2), .H_ACTIVE(8), .V_ACTIVE(5), .H_BLANK(3),
    .V_BLANK(6), .FV_LEAD(2), .FV_TRAIL(2), .CHK_SHIFT(CS)
  ) dut2 (
    .pixel_clk(clk), .pixel_rst_n(rst2_n), .enable(en2), .mode(mode2), .pix(pif2),
    .frame_count(frame_count2), .busy(busy2), .frame_crc(frame_crc2)
  );

  int total = 0;
  int bad   = 0;

  logic [PPC*DW-1:0] exp_q[$];
  int                fc_q[$];
  logic [15:0]       crc_q[$];
  logic [15:0]       lfsr_seq [HA*VA];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return pif.pixel_fv;
      1:       return pif.pixel_lv;
      default: return busy;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input logic val, input int budget);
    int n;
    n = 0;
    while (probe(which) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, probe(which), val);
  endtask

  function automatic logic [DW-1:0] ref_pix(input int m, input int x, input int y, input int fc,
                                            input logic [15:0] lf);
    int v;
    case (m)
      0:       v = ((x * 8) / HA) * (((1 << DW) - 1) / 7);
      1:       v = x + y + fc;
      2:       v = (((x >> CS) ^ (y >> CS)) & 1) ? (1 << DW) - 1 : 0;
      default: v = int'(lf);
    endcase
    return DW'(v);
  endfunction

  function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [DW-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = DW - 1; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
      else              r = r << 1;
    end
    return r;
  endfunction

  // Whole expected frame: words in raster order plus the end-of-frame count and CRC
  task automatic push_frame(input int m, input int fc);
    logic [PPC*DW-1:0] w;
    logic [DW-1:0]     px;
    logic [15:0]       crc;
    int                x;
    crc = 16'hFFFF;
    for (int y = 0; y < VA; y++) begin
      for (int c = 0; c < H_CYC; c++) begin
        w = '0;
        for (int k = 0; k < PPC; k++) begin
          x  = c * PPC + k;
          px = ref_pix(m, x, y, fc, lfsr_seq[y * HA + x]);
          w[k*DW +: DW] = px;
          crc = crc_px(crc, px);
        end
        exp_q.push_back(w);
      end
    end
    fc_q.push_back((fc + 1) & 16'hFFFF);
    crc_q.push_back(crc);
  endtask

  initial begin : build_lfsr
    int s, fb;
    s = 'hACE1;
    for (int p = 0; p < HA * VA; p++) begin
      fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
      s  = ((s << 1) & 'hFFFF) | fb;
      lfsr_seq[p] = 16'(s);
    end
  end

  int   lines = 0, run = 0, nz_data = 0;
  logic prev_fv = 1'b0, prev_lv = 1'b0;

  always @(negedge clk) begin : monitor
    logic [PPC*DW-1:0] w;
    logic [15:0]       ecrc;
    int                efc;
    if (!rst_n) begin
      lines = 0; run = 0; nz_data = 0; prev_fv = 1'b0; prev_lv = 1'b0;
    end else begin
      if (pif.pixel_fv && !prev_fv) begin
        lines = 0; nz_data = 0;
      end
      if (pif.pixel_lv && !prev_lv) begin
        lines++; run = 0;
      end
      if (pif.pixel_lv) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL word_underflow: got lv=1 with empty scoreboard");
        end else begin
          w = exp_q.pop_front();
          check($sformatf("pixel_data row%0d col%0d", lines - 1, run), pif.pixel_data, w);
        end
        run++;
      end else if (pif.pixel_data != '0) begin
        nz_data++;
      end
      if (!pif.pixel_lv && prev_lv) check("line_len", run, H_CYC);
      if (!pif.pixel_fv && prev_fv) begin
        check("lines_per_frame", lines, VA);
        check("data_zero_outside_lv", nz_data, 0);
        if (fc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL frame_underflow: got frame end with no expected frame");
        end else begin
          efc  = fc_q.pop_front();
          ecrc = crc_q.pop_front();
          check("frame_count", frame_count, efc);
`ifdef PATTERN_GEN_CRC_EN
          check("frame_crc", frame_crc, ecrc);
`else
          check("frame_crc", frame_crc, 16'h0000 & ecrc);
`endif
        end
      end
      prev_fv = pif.pixel_fv;
      prev_lv = pif.pixel_lv;
    end
  end

  initial begin : dut2_run
    int                rows, run2, guard;
    logic              pl;
    logic [2*DW-1:0]   w2;
    logic [DW-1:0]     lane;
    logic [15:0]       crc2;
    logic [2*DW-1:0]   row3 [4];
    row3   = '{20'd4099, 20'd6149, 20'd8199, 20'd10249};
    rst2_n = 1'b0; en2 = 1'b0; mode2 = 2'd1; done2 = 1'b0; crc2 = 16'hFFFF;
    repeat (3) @(negedge clk);
    rst2_n = 1'b1; en2 = 1'b1;
    for (int f = 0; f < 2; f++) begin
      guard = 0;
      while (!pif2.pixel_fv && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      check("dut2 fv_rise", pif2.pixel_fv, 1);
      rows = 0; run2 = 0; pl = 1'b0; guard = 0;
      while (pif2.pixel_fv && guard < 300) begin
        if (pif2.pixel_lv) begin
          if (!pl) begin
            rows++; run2 = 0;
          end
          for (int k = 0; k < 2; k++) begin
            lane = DW'(run2 * 2 + k + rows - 1 + f);
            w2[k*DW +: DW] = lane;
            if (f == 1) crc2 = crc_px(crc2, lane);
          end
          check("dut2 pixel_data", pif2.pixel_data, w2);
          if (f == 0 && rows == 4 && run2 < 4) check("dut2 row3 word", pif2.pixel_data, row3[run2]);
          run2++;
        end else if (pl) begin
          check("dut2 line_len", run2, 4);
        end
        pl = pif2.pixel_lv;
        @(negedge clk);
        guard++;
      end
      check("dut2 lines", rows, 5);
    end
    check("dut2 busy", busy2, 1);
    check("dut2 frame_count", frame_count2, 2);
`ifdef PATTERN_GEN_CRC_EN
    check("dut2 frame_crc", frame_crc2, crc2);
`else
    check("dut2 frame_crc", frame_crc2, 16'h0000 & crc2);
`endif
    en2   = 1'b0;
    done2 = 1'b1;
  end

  initial begin : stimulus
    int   modes [8];
    int   nm, rises, n;
    logic pl, idle_bad;
    modes = '{0, 3, 3, 2, 2, 1, 0, 0};
    modes[6] = $urandom_range(3, 0);
    modes[7] = $urandom_range(3, 0);
    rst_n = 1'b0; enable = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clk);
    check("reset fv", pif.pixel_fv, 0);
    check("reset lv", pif.pixel_lv, 0);
    check("reset data", pif.pixel_data, 0);
    check("reset frame_count", frame_count, 0);
    check("reset busy", busy, 0);
    check("reset frame_crc", frame_crc, 0);

    rst_n = 1'b1;
    mode  = 2'(modes[0]);
    push_frame(modes[0], 0);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_for("fv_rise", 0, 1'b1, 3000);
      mode = 2'($urandom_range(3, 0));
      wait_for("fv_fall", 0, 1'b0, 3000);
      nm   = (i < 7) ? modes[i + 1] : int'($urandom_range(3, 0));
      mode = 2'(nm);
      push_frame(nm, i + 1);
    end

    // frame 8: drop enable part-way through row 10
    wait_for("drop fv_rise", 0, 1'b1, 3000);
    rises = 0; n = 0; pl = 1'b0;
    while (rises < 11 && n < 3000) begin
      @(negedge clk);
      n++;
      if (pif.pixel_lv && !pl) rises++;
      pl = pif.pixel_lv;
    end
    check("drop reached row10", rises, 11);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    check("busy mid-frame", busy, 1);
    wait_for("drop fv_fall", 0, 1'b0, 3000);
    check("busy after trail", busy, 0);
    idle_bad = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (pif.pixel_fv || pif.pixel_lv || busy) idle_bad = 1'b1;
    end
    check("idle after disable", idle_bad, 0);
    check("frame_count after drop", frame_count, 9);

    // frame 9 is cut short by reset during ACTIVE
    nm   = $urandom_range(3, 0);
    mode = 2'(nm);
    push_frame(nm, 9);
    enable = 1'b1;
    wait_for("rst fv_rise", 0, 1'b1, 3000);
    wait_for("rst lv_rise", 1, 1'b1, 3000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete(); fc_q.delete(); crc_q.delete();
    #1;
    check("async rst fv", pif.pixel_fv, 0);
    check("async rst lv", pif.pixel_lv, 0);
    check("async rst data", pif.pixel_data, 0);
    check("async rst frame_count", frame_count, 0);
    check("async rst busy", busy, 0);
    check("async rst frame_crc", frame_crc, 0);
    repeat (3) @(negedge clk);
    nm   = $urandom_range(3, 0);
    mode = 2'(nm);
    push_frame(nm, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    // edge 1 leaves IDLE, V_BLANK cycles of VBLANK, then fv registers one edge after FV_LEAD entry
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #1;
      if (pif.pixel_fv) break;
    end
    check("fv_rise_latency", n, VB + 2);
    enable = 1'b0;
    wait_for("post-rst fv_fall", 0, 1'b0, 3000);
    repeat (4) @(negedge clk);
    check("post-rst frame_count", frame_count, 1);
    check("post-rst busy", busy, 0);

    n = 0;
    while (!done2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("dut2 done", done2, 1);
    check("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
